// File: rtl/imem_boot_pkg.sv
// imem_boot shared types: loader FSM states and stream framing constants.
// Used by imem_boot and byte_packer.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN
  } boot_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// 8-to-32 big-endian word assembler with a 2-bit byte index.
// word/word_valid present the completed word during the 4th byte's cycle.
module byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sr_q;
  logic [1:0]  idx_q;

  assign word       = {sr_q, din};
  assign word_valid = en && (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (en) begin
      sr_q  <= {sr_q[15:0], din};
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot.sv
// Instruction memory with serial boot loader; holds the core in reset until loaded.
// Optional trailing XOR checksum byte: define IMEM_BOOT_CHECKSUM_EN.
module imem_boot
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [CNT_W-1:0]  load_cnt,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam boot_state_t POST_DATA = S_CSUM;
`else
  localparam boot_state_t POST_DATA = S_RUN;
`endif

  boot_state_t      state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic [15:0]      hdr;
  logic             xfer, pack_en;
  logic             word_valid, in_range;
  logic [31:0]      word;
  logic [31:0]      mem [DEPTH];

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_d;
`endif

  assign xfer     = byte_valid & byte_ready;
  assign pack_en  = xfer && (state_q == S_DATA);
  assign cnt_inc  = load_cnt + CNT_W'(1);
  assign hdr      = {hi_q, byte_data};
  // Words past the array end are counted but dropped, never wrapped.
  assign in_range = (load_cnt >> ADDR_W) == '0;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .en         (pack_en),
    .din        (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    cnt_d   = load_cnt;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err;
    if (xfer && state_q != S_CSUM)
      csum_d = csum_q ^ byte_data;
`endif
    if (xfer) begin
      unique case (state_q)
        S_LEN_HI: begin
          hi_d    = byte_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = CNT_W'(hdr);
          state_d = (hdr == 16'd0) ? POST_DATA : S_DATA;
        end
        S_DATA: begin
          if (word_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q)
              state_d = POST_DATA;
          end
        end
        S_CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          if (byte_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_LEN_HI;
            cnt_d   = '0;
            csum_d  = 8'h00;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN_HI;
      hi_q       <= '0;
      len_q      <= '0;
      load_cnt   <= '0;
      byte_ready <= 1'b1;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      load_cnt   <= cnt_d;
      byte_ready <= (state_d != S_RUN);
      cpu_reset  <= (state_d != S_RUN);
      load_done  <= (state_d == S_RUN);
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= 8'h00;
      err    <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err    <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (word_valid && in_range)
      mem[load_cnt[ADDR_W-1:0]] <= word;
  end

  assign instr = mem[pc[ADDR_W+1:2]];

  logic unused_pc;
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_imem_boot.sv
// Randomized bench for imem_boot against a byte-offset reference model.
// Honours IMEM_BOOT_CHECKSUM_EN for stream framing and checksum tests.
module tb_imem_boot;

  localparam int AW    = 6;
  localparam int CW    = 16;
  localparam int DEPTH = 2 ** AW;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic [31:0]   pc = 32'h0;
  logic [31:0]   instr;
  logic          cpu_reset;
  logic          load_done;
  logic [CW-1:0] load_cnt;
  logic          err;

  always #5 clk = ~clk;

  imem_boot #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .pc         (pc),
    .instr      (instr),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_cnt   (load_cnt),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: image described by byte offsets
  logic [31:0] mmem [DEPTH];
  bit          mvalid [DEPTH];
  logic [31:0] mstage;
  logic [7:0]  mhi, mx;
  int          mk, mn;
  bit          mdone, merr;

  task automatic m_reset();
    mk = 0; mn = 0; mx = 8'h00; mdone = 1'b0; merr = 1'b0;
  endtask

  task automatic m_accept(input logic [7:0] b);
    int off;
    off = mk - 2;
    if (mk == 0) mhi = b;
    else if (mk == 1) mn = int'({mhi, b});
    else if (off < 4 * mn) begin
      mstage[31 - 8 * (off % 4) -: 8] = b;
      if (off % 4 == 3 && off / 4 < DEPTH) begin
        mmem[off / 4]   = mstage;
        mvalid[off / 4] = 1'b1;
      end
    end
    if (mk < 2 || off < 4 * mn) begin
      mx ^= b;
      mk++;
      if (!CS && mk == 2 + 4 * mn) mdone = 1'b1;
    end else if (b == mx) begin
      mdone = 1'b1;
    end else begin
      merr = 1'b1; mk = 0; mx = 8'h00;
    end
  endtask

  function automatic int exp_cnt();
    int w;
    if (mk < 2) return 0;
    w = (mk - 2) / 4;
    return (w < mn) ? w : mn;
  endfunction

  // stimulus
  logic [7:0]  q [$];
  logic [31:0] img [$];
  logic [7:0]  pcsum;
  int          vprob = 100;
  bit          toggle = 1'b0;
  bit          cmp_en = 1'b0;

  task automatic cycle();
    bit want;
    @(posedge clk);
    if (reset) m_reset();
    else if (byte_valid && !mdone) begin
      m_accept(byte_data);
      void'(q.pop_front());
    end
    #1;
    pc = $urandom;
    want = toggle ? !byte_valid : ($urandom_range(99) < vprob);
    if (q.size() > 0 && want) begin
      byte_valid = 1'b1;
      byte_data  = q[0];
    end else begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic push_image(input bit bad);
    logic [15:0] n16;
    logic [31:0] w;
    logic [7:0]  x, b;
    n16 = 16'(img.size());
    x = n16[15:8] ^ n16[7:0];
    q.push_back(n16[15:8]);
    q.push_back(n16[7:0]);
    foreach (img[i]) begin
      w = img[i];
      for (int j = 3; j >= 0; j--) begin
        b = w[8 * j +: 8];
        q.push_back(b);
        x ^= b;
      end
    end
    if (CS) q.push_back(bad ? ~x : x);
    pcsum = x;
  endtask

  task automatic drain(input int vp, input bit tg);
    int budget;
    budget = 4000;
    vprob = vp;
    toggle = tg;
    while (q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    q.delete();
    repeat (3) cycle();
  endtask

  task automatic peek(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
    pc = a;
    #1;
    chk(nm, instr, exp);
  endtask

  always @(negedge clk) begin : cmp
    int ix;
    if (cmp_en) begin
      chk("byte_ready", 32'(byte_ready), 32'(!mdone));
      chk("cpu_reset", 32'(cpu_reset), 32'(!mdone));
      chk("load_done", 32'(load_done), 32'(mdone));
      chk("load_cnt", 32'(load_cnt), 32'(exp_cnt()));
      chk("err", 32'(err), 32'(merr));
      ix = int'(pc[AW+1:2]);
      if (mvalid[ix]) chk("instr", instr, mmem[ix]);
    end
  end

  initial begin
    m_reset();
    do_reset();
    cmp_en = 1'b1;
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_cnt", 32'(load_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    img = '{32'h20080005, 32'hAC080054};
    push_image(1'b0);
    drain(100, 1'b0);
    chk("t1_model_m0", mmem[0], 32'h20080005);
    chk("t1_cnt", 32'(load_cnt), 32'd2);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_ready", 32'(byte_ready), 32'd0);
    peek("t1_pc0", 32'h0, 32'h20080005);
    peek("t1_pc4", 32'h4, 32'hAC080054);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      img.delete();
      for (int i = 0; i < $urandom_range(1, 10); i++)
        img.push_back($urandom);
      push_image(1'b0);
      drain($urandom_range(30, 100), 1'b0);
      chk("rnd_cnt", 32'(load_cnt), 32'(img.size()));
    end

    do_reset();
    img = '{32'h20080005, 32'hAC080054};
    push_image(1'b0);
    drain(100, 1'b1);
    chk("t2_cnt", 32'(load_cnt), 32'd2);
    peek("t2_pc0", 32'h0, 32'h20080005);
    peek("t2_pc4_alias", 32'hFFFF_FF07, 32'hAC080054);

    do_reset();
    img.delete();
    push_image(1'b0);
    drain(100, 1'b0);
    chk("t3_cnt", 32'(load_cnt), 32'd0);
    chk("t3_done", 32'(load_done), 32'd1);
    peek("t3_pc4", 32'h4, 32'hAC080054);

    do_reset();
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drain(100, 1'b0);
    do_reset();
    img = '{32'h12345678};
    push_image(1'b0);
    drain(100, 1'b0);
    chk("t4_cnt", 32'(load_cnt), 32'd1);
    peek("t4_pc0", 32'h0, 32'h12345678);
    peek("t4_pc4", 32'h4, 32'hAC080054);

    do_reset();
    img.delete();
    for (int i = 0; i < DEPTH + 2; i++) img.push_back($urandom);
    push_image(1'b0);
    drain(100, 1'b0);
    chk("ovf_cnt", 32'(load_cnt), 32'(DEPTH + 2));
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    peek("ovf_pc0", 32'h0, img[0]);

`ifdef IMEM_BOOT_CHECKSUM_EN
    do_reset();
    img = '{32'hDEADBEEF};
    push_image(1'b0);
    chk("cs_model_sum", 32'(pcsum), 32'h23);
    drain(100, 1'b0);
    chk("cs_ok_err", 32'(err), 32'd0);
    chk("cs_ok_done", 32'(load_done), 32'd1);
    do_reset();
    push_image(1'b1);
    drain(100, 1'b0);
    chk("cs_bad_err", 32'(err), 32'd1);
    chk("cs_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("cs_bad_ready", 32'(byte_ready), 32'd1);
    chk("cs_bad_cnt", 32'(load_cnt), 32'd0);
    img = '{32'hCAFEF00D};
    push_image(1'b0);
    drain(70, 1'b0);
    chk("cs_retry_done", 32'(load_done), 32'd1);
    chk("cs_retry_err", 32'(err), 32'd1);
    peek("cs_retry_pc0", 32'h0, 32'hCAFEF00D);
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
